// File: rtl/gfx_fb_write_sched.sv
// gfx_fb_write_sched
// Arbitrates the single framebuffer write port between the full-screen clear
// generator and the draw pixel stream. A clear (requested, or automatic after
// reset) restarts the generator, waits for it to settle, forwards its pixels
// until the last one is accepted, then returns the port to the draw stream.
//
// Handshake: a beat transfers on any cycle where valid & ready are both high.
// A producer never withdraws or changes a presented beat until it transfers.
// Data and ready paths are combinational pass-throughs with no buffering.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   clear_req                        single-cycle clear request
//   busy                             clear pending or in progress
//   clear_done                       one-cycle pulse after the last clear pixel
//   clr_start / clr_inc              generator restart / advance
//   clr_x/y/color/valid/last         generator pixel stream
//   draw_valid/ready, draw_x/y/color draw pixel stream
//   fb_valid/ready, fb_x/y/color     framebuffer write port
//   fsm_state                        current scheduler state (debug)
module gfx_fb_write_sched #(
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int CLEAR_ON_RESET = 1,
    parameter int SETTLE_CYCLES  = 2,
    localparam int FB_X_BITS     = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS     = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  clr_start,
    output logic                  clr_inc,
    input  logic [FB_X_BITS-1:0]  clr_x,
    input  logic [FB_Y_BITS-1:0]  clr_y,
    input  logic [PIXEL_BITS-1:0] clr_color,
    input  logic                  clr_valid,
    input  logic                  clr_last,
    input  logic                  draw_valid,
    output logic                  draw_ready,
    input  logic [FB_X_BITS-1:0]  draw_x,
    input  logic [FB_Y_BITS-1:0]  draw_y,
    input  logic [PIXEL_BITS-1:0] draw_color,
    output logic                  fb_valid,
    input  logic                  fb_ready,
    output logic [FB_X_BITS-1:0]  fb_x,
    output logic [FB_Y_BITS-1:0]  fb_y,
    output logic [PIXEL_BITS-1:0] fb_color,
    output logic [1:0]            fsm_state
);

    localparam int CNT_BITS = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_DRAW   = 2'd0,
        S_START  = 2'd1,
        S_SETTLE = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_START : S_DRAW;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [CNT_BITS-1:0] settle_q, settle_d;
    logic                done_q, done_d;
    logic                clr_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            pending_q <= 1'b0;
            settle_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        clr_start  = 1'b0;
        clr_inc    = 1'b0;
        draw_ready = 1'b0;
        fb_valid   = 1'b0;
        fb_x       = draw_x;
        fb_y       = draw_y;
        fb_color   = draw_color;
        clr_accept = fb_ready & clr_valid;

        case (state_q)
            S_DRAW: begin
                fb_valid   = draw_valid;
                draw_ready = fb_ready;
                if (clear_req) begin
                    pending_d = 1'b1;
                end
                // A draw beat stalled on fb_ready stays on the port until it
                // transfers, so the switch to the clear waits for it.
                if ((pending_q | clear_req) && !(draw_valid && !fb_ready)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                clr_start = 1'b1;
                pending_d = 1'b0;
                settle_d  = CNT_BITS'(SETTLE_CYCLES);
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                // The counter reaching zero marks the end of settling, so the
                // clear begins SETTLE_CYCLES + 1 cycles after the restart pulse.
                // Generator outputs may still be stale here and are not used.
                if (settle_q <= CNT_BITS'(1)) begin
                    settle_d = '0;
                    state_d  = S_CLEAR;
                end else begin
                    settle_d = settle_q - CNT_BITS'(1);
                end
            end
            S_CLEAR: begin
                fb_valid = clr_valid;
                fb_x     = clr_x;
                fb_y     = clr_y;
                fb_color = clr_color;
                clr_inc  = clr_accept;
                if (clr_accept && clr_last) begin
                    state_d = S_DRAW;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_DRAW;
            end
        endcase
    end

    assign busy       = (state_q != S_DRAW) | pending_q;
    assign clear_done = done_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_gfx_fb_write_sched.sv
// Testbench for gfx_fb_write_sched on a 4x2 framebuffer with clear-on-reset.
// Contains a clear generator model, a draw driver, a ready driver, a
// scoreboard of expected framebuffer writes and a per-cycle reference model
// of the scheduling rules, plus literal expectations for each scenario.
module tb_gfx_fb_write_sched;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PB = 12;
    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);
    localparam int SETTLE = 2;
    localparam int PW = XB + YB + PB;

    logic          clk, reset_n, clear_req;
    logic          busy, clear_done, clr_start, clr_inc;
    logic [XB-1:0] clr_x, draw_x, fb_x;
    logic [YB-1:0] clr_y, draw_y, fb_y;
    logic [PB-1:0] clr_color, draw_color, fb_color;
    logic          clr_valid, clr_last, draw_valid, draw_ready, fb_valid, fb_ready;
    logic [1:0]    fsm_state;

    gfx_fb_write_sched #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB),
        .CLEAR_ON_RESET(1), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
        .busy(busy), .clear_done(clear_done),
        .clr_start(clr_start), .clr_inc(clr_inc),
        .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color),
        .clr_valid(clr_valid), .clr_last(clr_last),
        .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
        .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back({XB'(x), YB'(y), PB'(0)});
    endtask

    // ---------------- clear generator model ----------------
    // After a restart it shows junk (flagged valid and last) for two cycles,
    // then walks the raster with colour 0 and goes idle after the last pixel.
    logic          g_live, g_en, g_stutter;
    int            g_wait;
    logic [XB-1:0] gx;
    logic [YB-1:0] gy;
    logic          s_start, s_inc, s_hold;

    initial begin
        g_live = 1'b0; g_en = 1'b1; g_stutter = 1'b0; g_wait = 0; gx = '0; gy = '0;
    end

    always_comb begin
        clr_valid = (g_live || g_wait > 0) && g_en;
        clr_x     = g_live ? gx : XB'(W - 1);
        clr_y     = g_live ? gy : YB'(H - 1);
        clr_color = g_live ? PB'(0) : PB'(12'hFFF);
        clr_last  = g_live ? (gx == XB'(W - 1) && gy == YB'(H - 1)) : 1'b1;
    end

    always begin
        @(negedge clk);
        s_start = clr_start;
        s_inc   = clr_inc;
        s_hold  = clr_valid && !clr_inc;
        @(posedge clk);
        #1;
        if (s_start) begin
            g_wait = 2; g_live = 1'b0;
        end else if (g_wait > 0) begin
            g_wait--;
            if (g_wait == 0) begin g_live = 1'b1; gx = '0; gy = '0; end
        end else if (g_live && s_inc) begin
            if (gx == XB'(W - 1) && gy == YB'(H - 1)) g_live = 1'b0;
            else if (gx == XB'(W - 1)) begin gx = '0; gy = gy + 1'b1; end
            else gx = gx + 1'b1;
        end
        if (!s_hold) g_en = g_stutter ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- ready driver ----------------
    // mode 0: fb_ready written directly by the test; 1: pattern; 2: random.
    int         rdy_mode = 0;
    int         pat_i = 0;
    logic [6:0] pat = 7'b1101101;

    always begin
        @(posedge clk);
        #2;
        if (rdy_mode == 1) begin
            fb_ready = pat[pat_i];
            pat_i = (pat_i == 6) ? 0 : pat_i + 1;
        end else if (rdy_mode == 2) begin
            fb_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- draw driver ----------------
    task automatic send_draw(input logic [XB-1:0] x, input logic [YB-1:0] y, input logic [PB-1:0] c);
        int n;
        draw_x = x; draw_y = y; draw_color = c; draw_valid = 1'b1;
        exp_q.push_back({x, y, c});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!draw_ready && n < 200);
        chk("draw_accept_timeout", n < 200, 1);
        @(posedge clk);
        #1;
        draw_valid = 1'b0;
    endtask

    // ---------------- reference model + compare ----------------
    logic          m_active, m_pending, m_done_next, prev_stall;
    int            m_age;
    logic [PW-1:0] prev_payload, got;
    int            cyc = 0, n_writes = 0, n_dones = 0, n_starts = 0;
    int            start_cyc = 0, first_wr_cyc = 0, done_cyc = 0;
    logic          wr_seen = 1'b0;

    initial begin
        m_active = 1'b1; m_pending = 1'b0; m_done_next = 1'b0; prev_stall = 1'b0; m_age = 0;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_fb_valid", fb_valid, 0);
            chk("rst_clr_start", clr_start, 1);
            chk("rst_draw_ready", draw_ready, 0);
            chk("rst_busy", busy, 1);
            chk("rst_clear_done", clear_done, 0);
            chk("rst_clr_inc", clr_inc, 0);
            m_active = 1'b1; m_age = 0; m_pending = 1'b0; m_done_next = 1'b0; prev_stall = 1'b0;
        end else begin
            cyc++;
            got = {fb_x, fb_y, fb_color};
            chk("clear_done", clear_done, m_done_next);
            m_done_next = 1'b0;
            chk("clr_start", clr_start, m_active && m_age == 0);
            if (prev_stall) begin
                chk("stall_valid_held", fb_valid, 1);
                chk("stall_payload_held", got, prev_payload);
            end
            if (m_active) begin
                chk("busy_clearing", busy, 1);
                chk("draw_ready_clearing", draw_ready, 0);
                if (m_age <= SETTLE) begin
                    chk("fb_valid_settle", fb_valid, 0);
                    chk("clr_inc_settle", clr_inc, 0);
                end else begin
                    chk("fb_valid_clear", fb_valid, clr_valid);
                    chk("clr_inc_clear", clr_inc, fb_ready & clr_valid);
                    if (clr_valid) chk("payload_clear", got, {clr_x, clr_y, clr_color});
                end
            end else begin
                chk("busy_draw", busy, m_pending);
                chk("draw_ready_draw", draw_ready, fb_ready);
                chk("clr_inc_draw", clr_inc, 0);
                chk("fb_valid_draw", fb_valid, draw_valid);
                if (draw_valid) chk("payload_draw", got, {draw_x, draw_y, draw_color});
            end
            if (clr_start) begin n_starts++; start_cyc = cyc; wr_seen = 1'b0; end
            if (clear_done) begin n_dones++; done_cyc = cyc; end
            if (fb_valid && fb_ready) begin
                n_writes++;
                if (!wr_seen) begin first_wr_cyc = cyc; wr_seen = 1'b1; end
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("write_payload", got, exp_q.pop_front());
            end
            // advance the model one cycle
            if (m_active) begin
                if (m_age > SETTLE && fb_ready && clr_valid && clr_last) begin
                    m_active = 1'b0; m_done_next = 1'b1;
                end else begin
                    m_age++;
                end
            end else if ((m_pending || clear_req) && !(draw_valid && !fb_ready)) begin
                m_active = 1'b1; m_age = 0; m_pending = 1'b0;
            end else if (clear_req) begin
                m_pending = 1'b1;
            end
            prev_stall   = fb_valid && !fb_ready;
            prev_payload = got;
        end
    end

    // ---------------- test helpers ----------------
    task automatic zero_counts();
        n_writes = 0; n_dones = 0; n_starts = 0;
    endtask

    task automatic wait_dones(input int target, input int limit);
        int n;
        n = 0;
        while (n_dones < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("clear_done_timeout", n_dones >= target, 1);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset_n = 1'b0; clear_req = 1'b0; fb_ready = 1'b1;
        draw_valid = 1'b0; draw_x = '0; draw_y = '0; draw_color = '0;

        // Boot clear
        push_clear();
        repeat (3) @(posedge clk);
        #1; zero_counts(); reset_n = 1'b1;
        wait_dones(1, 100);
        chk("boot_starts", n_starts, 1);
        chk("boot_first_write_latency", first_wr_cyc - start_cyc, 3);
        chk("boot_done_latency", done_cyc - start_cyc, 11);
        chk("boot_writes", n_writes, 8);
        chk("boot_queue_empty", exp_q.size(), 0);
        chk("boot_busy_at_done", busy, 0);
        repeat (3) @(posedge clk);
        #1; chk("boot_single_done", n_dones, 1);

        // Draw pass-through with ready pattern 1,0,1,1,0,1,1
        zero_counts(); pat_i = 0; rdy_mode = 1;
        for (int i = 0; i < 5; i++)
            send_draw(XB'(i), YB'(i % 2), PB'(12'h111 * (i + 1)));
        rdy_mode = 0; fb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("draw_writes", n_writes, 5);
        chk("draw_queue_empty", exp_q.size(), 0);
        chk("draw_no_start", n_starts, 0);

        // Stalled switch
        zero_counts(); fb_ready = 1'b0;
        fork
            send_draw(XB'(2), YB'(1), PB'(12'h123));
            begin
                pulse_clear();
                push_clear();
                repeat (2) @(posedge clk);
                @(negedge clk); #1;
                chk("stall_busy", busy, 1);
                chk("stall_no_start", clr_start, 0);
                chk("stall_fb_x", fb_x, 2);
                chk("stall_fb_color", fb_color, 12'h123);
                @(posedge clk); #1; fb_ready = 1'b1;
            end
        join
        @(negedge clk); #1;
        chk("stall_start_after_accept", clr_start, 1);
        wait_dones(1, 100);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Backpressure during clear
        repeat (2) @(posedge clk);
        #1; zero_counts(); rdy_mode = 2; g_stutter = 1'b1;
        push_clear();
        pulse_clear();
        wait_dones(1, 500);
        rdy_mode = 0; fb_ready = 1'b1; g_stutter = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_writes", n_writes, 8);
        chk("bp_queue_empty", exp_q.size(), 0);
        chk("bp_dones", n_dones, 1);

        // Dropped requests in SETTLE, mid-CLEAR and on the completion cycle
        zero_counts();
        push_clear();
        pulse_clear();
        n = 0;
        while (n_starts < 1 && n < 50) begin @(posedge clk); n++; end
        #1; clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        n = 0;
        while (n_writes < 2 && n < 50) begin @(posedge clk); n++; end
        #1; clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        n = 0;
        while (n_writes < 7 && n < 50) begin @(posedge clk); n++; end
        #1; clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("drop_starts", n_starts, 1);
        chk("drop_dones", n_dones, 1);
        chk("drop_busy", busy, 0);
        chk("drop_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-clear
        push_clear();
        pulse_clear();
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(fb_valid && fb_x == XB'(3) && fb_y == YB'(0)) && n < 100);
        chk("arst_reached_pixel3", n < 100, 1);
        #1; reset_n = 1'b0;
        #1;
        chk("arst_fb_valid_now", fb_valid, 0);
        chk("arst_clr_start_now", clr_start, 1);
        chk("arst_busy_now", busy, 1);
        exp_q.delete();
        push_clear();
        repeat (2) @(posedge clk);
        #1; zero_counts(); reset_n = 1'b1;
        wait_dones(1, 100);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_starts", n_starts, 1);
        chk("arst_first_write_latency", first_wr_cyc - start_cyc, 3);
        chk("arst_writes", n_writes, 8);
        chk("arst_dones", n_dones, 1);
        chk("arst_queue_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gfx_fb_write_sched.md
Name: gfx_fb_write_sched

Overview:
- Schedules the single framebuffer write port between the full-screen clear generator and the draw pixel stream.
- Sequences a clear on request, or on reset: restarts the generator, forwards its pixels until the last pixel is accepted, then hands the port back to the draw stream.
- Sits between the clear generator, the drawing pipeline and the framebuffer write adapter.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels; FB_X_BITS = $clog2(FB_WIDTH)
FB_HEIGHT, 480, framebuffer height in pixels; FB_Y_BITS = $clog2(FB_HEIGHT)
PIXEL_BITS, 12, colour width
CLEAR_ON_RESET, 1, 1 = perform a clear automatically on leaving reset
SETTLE_CYCLES, 2, cycles between the generator restart pulse and first acceptance of its outputs

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear_req  in  1  single-cycle clear request
busy  out  1  high while a clear is pending or in progress
clear_done  out  1  one-cycle pulse, the cycle after the last clear pixel is accepted
clr_start  out  1  generator restart (drives generator reset), high for exactly one cycle
clr_inc  out  1  advance generator; = fb_ready & clr_valid in CLEAR state, else 0
clr_x  in  FB_X_BITS  generator x
clr_y  in  FB_Y_BITS  generator y
clr_color  in  PIXEL_BITS  generator colour
clr_valid  in  1  generator valid
clr_last  in  1  generator at last pixel
draw_valid  in  1  draw pixel valid
draw_ready  out  1  draw pixel accepted when draw_valid & draw_ready
draw_x  in  FB_X_BITS  draw x
draw_y  in  FB_Y_BITS  draw y
draw_color  in  PIXEL_BITS  draw colour
fb_valid  out  1  write valid to framebuffer
fb_ready  in  1  framebuffer accepts write
fb_x  out  FB_X_BITS  write x
fb_y  out  FB_Y_BITS  write y
fb_color  out  PIXEL_BITS  write colour

Behaviour:
- States: DRAW, START, SETTLE, CLEAR.
- Reset (async, reset_n low):
  - state = START if CLEAR_ON_RESET else DRAW.
  - pending=0, settle counter=0, clear_done=0.
  - Outputs follow state decode.
- DRAW:
  - fb_* = draw_*; draw_ready = fb_ready (combinational); clr_inc = 0.
  - clear_req sets pending.
  - Go to START when (pending | clear_req) and no stalled beat (!(draw_valid & !fb_ready)).
  - Stalled beat: a presented draw beat is never withdrawn; the switch waits until it is accepted or draw_valid drops.
- START:
  - clr_start = 1, fb_valid = 0, draw_ready = 0.
  - pending cleared; load settle counter = SETTLE_CYCLES.
  - Next cycle -> SETTLE.
- SETTLE:
  - fb_valid = 0, draw_ready = 0, clr_* ignored (may be stale from the previous run).
  - Decrement the counter; at 0 -> CLEAR.
  - With SETTLE_CYCLES = 2, CLEAR is entered exactly 3 cycles after START.
- CLEAR:
  - fb_x/y/color = clr_*; fb_valid = clr_valid; draw_ready = 0; clr_inc = fb_ready & clr_valid.
  - On clr_inc & clr_last -> DRAW; clear_done = 1 on the following cycle only.
  - Generator outputs after last are never forwarded.
- busy = (state != DRAW) | pending.
- clear_req in START/SETTLE/CLEAR is dropped: no queued second clear.
- clear_req in the same cycle the clear completes is also dropped.
- fb_valid never asserted in START/SETTLE.
- fb_* payload is don't-care when fb_valid = 0, but must be held stable while fb_valid & !fb_ready.
- Reset mid-clear: aborts immediately.
  - CLEAR_ON_RESET=1: restarts from START (clr_start pulses again).
  - CLEAR_ON_RESET=0: returns to DRAW with no clear_done.
- Latency: zero-cycle combinational pass-through on data and ready paths; no buffering.
- Throughput: one pixel per cycle in both streams when fb_ready = 1.

Test Plan:
- Boot clear: FB 4x2, CLEAR_ON_RESET=1, fb_ready=1, reset_n released → clr_start pulses once at cycle 0; fb_valid rises no earlier than cycle 3; exactly 8 writes, (0,0)..(3,1), colour 0; clear_done pulses once; busy drops the same cycle.
- Draw pass-through: state DRAW, draw_valid=1 for 5 pixels, fb_ready toggling 1,0,1,1,0,1,1 → fb_* equals draw_* each cycle; draw_ready mirrors fb_ready; 5 accepted writes, no loss or duplication.
- Stalled switch: draw_valid=1, fb_ready=0, clear_req pulse → stays in DRAW with busy=1 and payload held; fb_ready=1 for one cycle → beat accepted, then START next cycle.
- Backpressure during clear: FB 4x2, fb_ready random 50% → exactly 8 distinct writes in raster order; clr_inc asserted only with fb_ready & clr_valid; no write after (3,1).
- Dropped request: clear_req pulsed in SETTLE and mid-CLEAR → only one clear_done; return to DRAW with pending=0.
- Async reset mid-clear: reset_n low at pixel 3 for 2 cycles, asynchronously without a clock edge → fb_valid=0 immediately; on release a full 8-pixel clear restarts with a fresh clr_start.
